load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the data-memory interface: accepts one load/store per handshake from the
//  execute stage, drives a word-organised memory bus (req/gnt, rvalid) with byte enables, and
//  returns load data sign/zero-extended per funct3. Misaligned accesses are split into two beats.
//  Sits between the pipeline MEM stage and the byte-addressed data memory.
// PARAMETERS
//  ADDR_WIDTH  32  byte address width; mem_addr is always word-aligned (bits [1:0] = 0)
//  DATA_WIDTH  32  data width; fixed 4 byte lanes
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  req_valid    in   1   access request valid
//  req_ready    out  1   LSU can accept (high only in IDLE)
//  req_we       in   1   1 = store, 0 = load
//  req_funct3   in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, right-aligned
//  resp_valid   out  1   one-cycle pulse: access complete
//  resp_rdata   out  32  extended load data (0 for stores/errors)
//  resp_err     out  1   valid with resp_valid: illegal funct3 or unsupported misalignment
//  mem_req      out  1   memory beat request
//  mem_gnt      in   1   beat accepted this cycle
//  mem_we       out  1   beat is a write
//  mem_addr     out  32  word-aligned beat address
//  mem_be       out  4   byte enables
//  mem_wdata    out  32  lane-shifted write data
//  mem_rvalid   in   1   beat done (reads and writes), >=1 cycle after gnt; mem_rdata valid
//  mem_rdata    in   32  read word
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; resp_valid/resp_err/mem_req/mem_we=0; all data outputs 0.
//  Reset mid-access abandons it immediately: mem_req drops asynchronously, no response issued.
//  FSM: IDLE -> ISSUE0 -> WAIT0 -> [ISSUE1 -> WAIT1] -> RESP -> IDLE.
//   IDLE: on req_valid&req_ready capture request; legal -> ISSUE0, illegal -> RESP with err.
//   ISSUEn: mem_req=1, outputs stable until mem_gnt; on gnt -> WAITn (mem_req low next cycle).
//   WAITn: on mem_rvalid latch lanes; beat0 of split -> ISSUE1, else -> RESP.
//   RESP: resp_valid=1 exactly one cycle, then IDLE (req_ready=1 that same cycle is not allowed).
//  Illegal: funct3 011/110/111, or store with funct3[2]=1. No memory beat issued.
//  Lane math: off=addr[1:0], mask={0001,0011,1111}[size]; m8=mask<<off (8-bit);
//   beat0 addr={addr[31:2],00}, be=m8[3:0], wdata=wd<<(8*off);
//   beat1 addr=beat0+4 (mod 2^32 wraps), be=m8[7:4], wdata=wd>>(32-8*off).
//   Split iff m8[7:4]!=0. Load assembles bytes from both beats, then extends per funct3.
//  Latency (gnt same cycle as req, rvalid next): aligned accept@T -> resp_valid@T+3; split @T+5.
//  mem_gnt and mem_rvalid in the same cycle: treat gnt only; rvalid outside WAITn is ignored.
// CONFIGURATION
//  LSU_MISALIGN_SPLIT_EN defined: misaligned accesses split into two beats as above.
//  Not defined: any access with m8[7:4]!=0 returns resp_err=1, no memory beat; FSM has no
//  ISSUE1/WAIT1 states.
// STRUCTURE
//  lsu_pkg: funct3 enum (F3_B..F3_HU), lsu_state_e, size_mask() function, BYTE_LANES=4.
//  Sub-module lsu_align: combinational lane shift for writes, byte merge + extension for reads.
// TESTING
//  LW 0x100, mem word 0x8081_8283 -> one beat be=1111, resp_rdata=0x8081_8283, err=0.
//  LB 0x103, word 0x80_00_00_00 -> be=1000, rdata=0xFFFF_FF80; LBU same -> 0x0000_0080.
//  SH 0x102 wd=0x0000_BEEF -> addr 0x100 be=1100 wdata=0xBEEF_0000, resp_valid, rdata=0.
//  SW 0x0FFF_FFFE wd=0x1122_3344 (SPLIT_EN) -> beat0 0x0FFF_FFFC be=1100 wdata 0x3344_0000;
//   beat1 0x1000_0000 be=0011 wdata 0x0000_1122; without macro -> resp_err=1, no mem_req.
//  LH 0xFFFF_FFFF (SPLIT_EN) -> beat1 addr 0x0000_0000 (wrap); funct3=011 -> err, no beat.
//  Hold mem_gnt low 5 cycles: mem_* stable; assert rst_n low in WAIT0 -> mem_req 0, IDLE, no resp.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
//  - funct3_e     : load/store width encodings (B, H, W, BU, HU)
//  - lsu_state_e  : access FSM states; ISSUE1/WAIT1 exist only when
//                   LSU_MISALIGN_SPLIT_EN is defined
//  - size_mask()  : contiguous byte mask for an access size
//  - lane_mask8() : that mask shifted to the byte offset across two words
//  - f3_legal()   : legal funct3 / direction combinations
package lsu_pkg;

  localparam int BYTE_LANES = 4;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE0,
    S_WAIT0,
`ifdef LSU_MISALIGN_SPLIT_EN
    S_ISSUE1,
    S_WAIT1,
`endif
    S_RESP
  } lsu_state_e;

  function automatic logic [BYTE_LANES-1:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Lower nibble covers the first word, upper nibble spills into the next one.
  function automatic logic [2*BYTE_LANES-1:0] lane_mask8(input logic [1:0] size,
                                                          input logic [1:0] off);
    return {{BYTE_LANES{1'b0}}, size_mask(size)} << off;
  endfunction

  // Unsigned variants only make sense for loads.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Bundle of the LSU request/response handshake and the data-memory bus.
// Modports:
//  master : the LSU (accepts requests, initiates memory beats)
//  slave  : the environment (execute stage + data memory)
// Signals: req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata,
//          resp_valid/resp_rdata/resp_err,
//          mem_req/mem_gnt/mem_we/mem_addr/mem_be/mem_wdata/mem_rvalid/mem_rdata.
interface lsu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [2:0]              req_funct3;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic                    resp_valid;
  logic [DATA_WIDTH-1:0]   resp_rdata;
  logic                    resp_err;
  logic                    mem_req;
  logic                    mem_gnt;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    mem_rvalid;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
           mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
           mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering for the LSU.
// Ports:
//  off        in  byte offset of the access within its first word
//  funct3     in  access width / signedness
//  beat_sel   in  0 = first beat lanes, 1 = spill-over lanes of the second beat
//  wdata      in  right-aligned store data
//  lo_word    in  read word from the first beat
//  hi_word    in  read word from the second beat (zero when not split)
//  beat_wdata out store data shifted onto the lanes of the selected beat
//  rdata      out load data realigned and sign/zero-extended
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            off,
  input  logic [2:0]            funct3,
  input  logic                  beat_sel,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] lo_word,
  input  logic [DATA_WIDTH-1:0] hi_word,
  output logic [DATA_WIDTH-1:0] beat_wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [2*DATA_WIDTH-1:0] wide_w;
  logic [2*DATA_WIDTH-1:0] wide_r;
  logic [DATA_WIDTH-1:0]   merged;

  always_comb begin
    // Shift across a double word so the bytes pushed out of beat 0 land in beat 1.
    wide_w     = {{DATA_WIDTH{1'b0}}, wdata} << {off, 3'b000};
    beat_wdata = beat_sel ? wide_w[2*DATA_WIDTH-1:DATA_WIDTH] : wide_w[DATA_WIDTH-1:0];

    wide_r = {hi_word, lo_word} >> {off, 3'b000};
    merged = wide_r[DATA_WIDTH-1:0];
    case (funct3)
      F3_B:    rdata = {{(DATA_WIDTH-8){merged[7]}}, merged[7:0]};
      F3_H:    rdata = {{(DATA_WIDTH-16){merged[15]}}, merged[15:0]};
      F3_BU:   rdata = {{(DATA_WIDTH-8){1'b0}}, merged[7:0]};
      F3_HU:   rdata = {{(DATA_WIDTH-16){1'b0}}, merged[15:0]};
      default: rdata = merged;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: takes one access per handshake from the MEM stage, runs
// it over a word-organised req/gnt/rvalid memory bus with byte enables and
// returns extended load data with a one-cycle resp_valid pulse.
// Ports: clk, rst_n (async, active low), bus (lsu_if.master: request,
// response and memory-bus signals).
// Build option: LSU_MISALIGN_SPLIT_EN -- when defined, accesses crossing a
// word boundary are done as two beats; otherwise they complete with
// resp_err and never touch memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst_n,
  lsu_if.master bus
);

  lsu_state_e              state_q, state_d;
  logic                    we_q, we_d;
  logic [2:0]              f3_q, f3_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   lo_q, lo_d;
  logic                    err_q, err_d;
  logic [BYTE_LANES-1:0]   be0_q, be0_d;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [BYTE_LANES-1:0]   be1_q, be1_d;
  logic [DATA_WIDTH-1:0]   hi_q, hi_d;
`else
  logic                    req_split;
`endif

  logic [2*BYTE_LANES-1:0] req_m8;
  logic [DATA_WIDTH-1:0]   hi_word;
  logic [DATA_WIDTH-1:0]   al_wdata;
  logic [DATA_WIDTH-1:0]   al_rdata;
  logic                    beat_sel;
  logic [ADDR_WIDTH-1:0]   beat0_addr;

  assign beat0_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign req_m8     = lane_mask8(bus.req_funct3[1:0], bus.req_addr[1:0]);

`ifdef LSU_MISALIGN_SPLIT_EN
  assign hi_word  = hi_q;
  assign beat_sel = (state_q == S_ISSUE1);
`else
  assign req_split = |req_m8[2*BYTE_LANES-1:BYTE_LANES];
  assign hi_word   = '0;
  assign beat_sel  = 1'b0;
`endif

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .off       (addr_q[1:0]),
    .funct3    (f3_q),
    .beat_sel  (beat_sel),
    .wdata     (wdata_q),
    .lo_word   (lo_q),
    .hi_word   (hi_word),
    .beat_wdata(al_wdata),
    .rdata     (al_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
      be0_q   <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      be1_q   <= '0;
      hi_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
      be0_q   <= be0_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      be1_q   <= be1_d;
      hi_q    <= hi_d;
`endif
    end
  end

  // Bus outputs are decoded from state only, so an async reset drops mem_req at once.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lo_d    = lo_q;
    err_d   = err_q;
    be0_d   = be0_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    be1_d   = be1_q;
    hi_d    = hi_q;
`endif
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_rdata = '0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_be     = '0;
    bus.mem_wdata  = '0;

    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          f3_d    = bus.req_funct3;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          be0_d   = req_m8[BYTE_LANES-1:0];
`ifdef LSU_MISALIGN_SPLIT_EN
          be1_d   = req_m8[2*BYTE_LANES-1:BYTE_LANES];
          err_d   = !f3_legal(bus.req_we, bus.req_funct3);
`else
          err_d   = !f3_legal(bus.req_we, bus.req_funct3) || req_split;
`endif
          state_d = err_d ? S_RESP : S_ISSUE0;
        end
      end
      S_ISSUE0: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = beat0_addr;
        bus.mem_be    = be0_q;
        bus.mem_wdata = al_wdata;
        if (bus.mem_gnt) state_d = S_WAIT0;
      end
      S_WAIT0: begin
        if (bus.mem_rvalid) begin
          lo_d = bus.mem_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
          state_d = (|be1_q) ? S_ISSUE1 : S_RESP;
`else
          state_d = S_RESP;
`endif
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      S_ISSUE1: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = beat0_addr + ADDR_WIDTH'(4);
        bus.mem_be    = be1_q;
        bus.mem_wdata = al_wdata;
        if (bus.mem_gnt) state_d = S_WAIT1;
      end
      S_WAIT1: begin
        if (bus.mem_rvalid) begin
          hi_d    = bus.mem_rdata;
          state_d = S_RESP;
        end
      end
`endif
      S_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
        bus.resp_rdata = (we_q || err_q) ? '0 : al_rdata;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit. A task plays the execute
// stage and the data memory and records what it saw; each test task then
// compares the record against hand-computed values.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_pass = 0;
  int n_total = 0;

  int          nbeats;
  int          latency;
  logic [31:0] b_addr [2];
  logic [31:0] b_wdata[2];
  logic [3:0]  b_be   [2];
  logic        b_we   [2];
  logic [31:0] o_rdata;
  logic        o_err, o_stable, o_ready_at_resp, o_post_valid, o_post_ready;

  task automatic idle_inputs();
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
  endtask

  // One access; memory grants after gnt_delay stalled cycles, rvalid the next cycle.
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int gnt_delay,
                           input logic [31:0] rd0, input logic [31:0] rd1);
    int stall;
    logic gnt_prev, seen;
    logic [31:0] s_addr, s_wdata;
    logic [3:0] s_be;
    logic s_we;
    nbeats = 0; latency = -1; o_rdata = 32'hDEAD_DEAD; o_err = 1'bx;
    o_stable = 1'b1; o_ready_at_resp = 1'bx;
    for (int i = 0; i < 2; i++) begin
      b_addr[i] = 32'h0; b_wdata[i] = 32'h0; b_be[i] = 4'h0; b_we[i] = 1'b0;
    end
    stall = 0; gnt_prev = 1'b0; seen = 1'b0;
    s_addr = 32'h0; s_wdata = 32'h0; s_be = 4'h0; s_we = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      bus.req_valid  = 1'b0;
      bus.mem_rvalid = gnt_prev;
      bus.mem_rdata  = gnt_prev ? ((nbeats == 1) ? rd0 : rd1) : 32'h0;
      gnt_prev = 1'b0;
      bus.mem_gnt = 1'b0;
      if (bus.mem_req === 1'b1) begin
        if (!seen) begin
          seen = 1'b1; s_addr = bus.mem_addr; s_wdata = bus.mem_wdata;
          s_be = bus.mem_be; s_we = bus.mem_we;
        end else if (bus.mem_addr !== s_addr || bus.mem_wdata !== s_wdata ||
                     bus.mem_be !== s_be || bus.mem_we !== s_we) begin
          o_stable = 1'b0;
        end
        if (stall < gnt_delay) begin
          stall++;
        end else begin
          bus.mem_gnt = 1'b1; gnt_prev = 1'b1;
          if (nbeats < 2) begin
            b_addr[nbeats] = bus.mem_addr; b_wdata[nbeats] = bus.mem_wdata;
            b_be[nbeats] = bus.mem_be; b_we[nbeats] = bus.mem_we;
          end
          nbeats++; seen = 1'b0; stall = 0;
        end
      end
      if (bus.resp_valid === 1'b1) begin
        latency = k; o_rdata = bus.resp_rdata; o_err = bus.resp_err;
        o_ready_at_resp = bus.req_ready;
        break;
      end
    end
    @(negedge clk);
    idle_inputs();
    o_post_valid = bus.resp_valid;
    o_post_ready = bus.req_ready;
  endtask

  task automatic test_reset();
    #12;
    n_total++; if (bus.req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.req_ready); else n_pass++;
    n_total++; if (bus.resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b want 0", bus.resp_valid); else n_pass++;
    n_total++; if (bus.resp_err !== 1'b0) $display("FAIL reset_resp_err got %b want 0", bus.resp_err); else n_pass++;
    n_total++; if (bus.resp_rdata !== 32'h0) $display("FAIL reset_resp_rdata got %h want 0", bus.resp_rdata); else n_pass++;
    n_total++; if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) $display("FAIL reset_mem_req_we got %b%b want 00", bus.mem_req, bus.mem_we); else n_pass++;
    n_total++; if (bus.mem_addr !== 32'h0 || bus.mem_be !== 4'h0 || bus.mem_wdata !== 32'h0)
      $display("FAIL reset_mem_data got %h/%b/%h want 0/0000/0", bus.mem_addr, bus.mem_be, bus.mem_wdata); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lw();
    do_access(1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, 32'h8081_8283, 32'h0);
    n_total++; if (nbeats !== 1) $display("FAIL lw_beats got %0d want 1", nbeats); else n_pass++;
    n_total++; if (b_addr[0] !== 32'h100 || b_be[0] !== 4'b1111 || b_we[0] !== 1'b0)
      $display("FAIL lw_beat got %h/%b/%b want 00000100/1111/0", b_addr[0], b_be[0], b_we[0]); else n_pass++;
    n_total++; if (o_rdata !== 32'h8081_8283 || o_err !== 1'b0) $display("FAIL lw_resp got %h/%b want 80818283/0", o_rdata, o_err); else n_pass++;
    n_total++; if (latency !== 3) $display("FAIL lw_latency got %0d want 3", latency); else n_pass++;
    n_total++; if (o_ready_at_resp !== 1'b0 || o_post_valid !== 1'b0 || o_post_ready !== 1'b1)
      $display("FAIL lw_resp_pulse got ready@resp=%b valid_after=%b ready_after=%b want 0/0/1", o_ready_at_resp, o_post_valid, o_post_ready); else n_pass++;
  endtask

  task automatic test_lb_lbu();
    do_access(1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 32'h8000_0000, 32'h0);
    n_total++; if (b_be[0] !== 4'b1000 || b_addr[0] !== 32'h100) $display("FAIL lb_beat got %h/%b want 00000100/1000", b_addr[0], b_be[0]); else n_pass++;
    n_total++; if (o_rdata !== 32'hFFFF_FF80) $display("FAIL lb_rdata got %h want ffffff80", o_rdata); else n_pass++;
    do_access(1'b0, 3'b100, 32'h0000_0103, 32'h0, 0, 32'h8000_0000, 32'h0);
    n_total++; if (o_rdata !== 32'h0000_0080 || o_err !== 1'b0) $display("FAIL lbu_rdata got %h/%b want 00000080/0", o_rdata, o_err); else n_pass++;
    do_access(1'b0, 3'b101, 32'h0000_0202, 32'h0, 0, 32'h8001_0000, 32'h0);
    n_total++; if (o_rdata !== 32'h0000_8001 || b_be[0] !== 4'b1100) $display("FAIL lhu_rdata got %h/%b want 00008001/1100", o_rdata, b_be[0]); else n_pass++;
  endtask

  task automatic test_sh();
    do_access(1'b1, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 0, 32'h1234_5678, 32'h0);
    n_total++; if (b_addr[0] !== 32'h100 || b_be[0] !== 4'b1100 || b_we[0] !== 1'b1)
      $display("FAIL sh_beat got %h/%b/%b want 00000100/1100/1", b_addr[0], b_be[0], b_we[0]); else n_pass++;
    n_total++; if (b_wdata[0] !== 32'hBEEF_0000) $display("FAIL sh_wdata got %h want beef0000", b_wdata[0]); else n_pass++;
    n_total++; if (latency !== 3 || o_rdata !== 32'h0 || o_err !== 1'b0)
      $display("FAIL sh_resp got lat=%0d rdata=%h err=%b want 3/0/0", latency, o_rdata, o_err); else n_pass++;
  endtask

  task automatic test_sw_split();
    do_access(1'b1, 3'b010, 32'h0FFF_FFFE, 32'h1122_3344, 0, 32'h0, 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
    n_total++; if (nbeats !== 2) $display("FAIL sw_split_beats got %0d want 2", nbeats); else n_pass++;
    n_total++; if (b_addr[0] !== 32'h0FFF_FFFC || b_be[0] !== 4'b1100 || b_wdata[0] !== 32'h3344_0000)
      $display("FAIL sw_split_beat0 got %h/%b/%h want 0ffffffc/1100/33440000", b_addr[0], b_be[0], b_wdata[0]); else n_pass++;
    n_total++; if (b_addr[1] !== 32'h1000_0000 || b_be[1] !== 4'b0011 || b_wdata[1] !== 32'h0000_1122)
      $display("FAIL sw_split_beat1 got %h/%b/%h want 10000000/0011/00001122", b_addr[1], b_be[1], b_wdata[1]); else n_pass++;
    n_total++; if (latency !== 5 || o_err !== 1'b0) $display("FAIL sw_split_resp got lat=%0d err=%b want 5/0", latency, o_err); else n_pass++;
`else
    n_total++; if (nbeats !== 0) $display("FAIL sw_mis_beats got %0d want 0", nbeats); else n_pass++;
    n_total++; if (latency < 1 || o_err !== 1'b1 || o_rdata !== 32'h0)
      $display("FAIL sw_mis_resp got lat=%0d err=%b rdata=%h want err=1 rdata=0", latency, o_err, o_rdata); else n_pass++;
`endif
  endtask

  task automatic test_lh_wrap();
    do_access(1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0, 0, 32'hAB00_0000, 32'h0000_00CD);
`ifdef LSU_MISALIGN_SPLIT_EN
    n_total++; if (b_addr[0] !== 32'hFFFF_FFFC || b_be[0] !== 4'b1000)
      $display("FAIL lh_wrap_beat0 got %h/%b want fffffffc/1000", b_addr[0], b_be[0]); else n_pass++;
    n_total++; if (b_addr[1] !== 32'h0000_0000 || b_be[1] !== 4'b0001)
      $display("FAIL lh_wrap_beat1 got %h/%b want 00000000/0001", b_addr[1], b_be[1]); else n_pass++;
    n_total++; if (o_rdata !== 32'hFFFF_CDAB || o_err !== 1'b0) $display("FAIL lh_wrap_rdata got %h/%b want ffffcdab/0", o_rdata, o_err); else n_pass++;
`else
    n_total++; if (nbeats !== 0 || o_err !== 1'b1) $display("FAIL lh_mis_err got beats=%0d err=%b want 0/1", nbeats, o_err); else n_pass++;
`endif
  endtask

  task automatic test_illegal();
    do_access(1'b0, 3'b011, 32'h0000_0100, 32'h0, 0, 32'h5555_5555, 32'h0);
    n_total++; if (nbeats !== 0 || latency < 1 || o_err !== 1'b1 || o_rdata !== 32'h0)
      $display("FAIL illegal_011 got beats=%0d lat=%0d err=%b rdata=%h want 0/>0/1/0", nbeats, latency, o_err, o_rdata); else n_pass++;
    do_access(1'b1, 3'b100, 32'h0000_0100, 32'h55, 0, 32'h0, 32'h0);
    n_total++; if (nbeats !== 0 || o_err !== 1'b1) $display("FAIL illegal_sbu got beats=%0d err=%b want 0/1", nbeats, o_err); else n_pass++;
  endtask

  task automatic test_gnt_stall();
    do_access(1'b1, 3'b010, 32'h0000_0200, 32'hCAFE_F00D, 5, 32'h0, 32'h0);
    n_total++; if (o_stable !== 1'b1) $display("FAIL stall_stable got %b want 1", o_stable); else n_pass++;
    n_total++; if (b_wdata[0] !== 32'hCAFE_F00D || b_be[0] !== 4'b1111 || b_addr[0] !== 32'h200)
      $display("FAIL stall_beat got %h/%b/%h want 00000200/1111/cafef00d", b_addr[0], b_be[0], b_wdata[0]); else n_pass++;
    n_total++; if (latency !== 8) $display("FAIL stall_latency got %0d want 8", latency); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int resp_seen;
    // Reset while the beat is still being offered: mem_req must fall without a clock edge.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h300;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_total++; if (bus.mem_req !== 1'b1) $display("FAIL rst_issue_req got %b want 1", bus.mem_req); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (bus.mem_req !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL rst_async_drop got req=%b ready=%b want 0/1", bus.mem_req, bus.req_ready); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    // Reset in WAIT0, then a late rvalid that must be ignored.
    @(negedge clk);
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
    resp_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      if (bus.resp_valid === 1'b1) resp_seen++;
    end
    n_total++; if (resp_seen !== 0) $display("FAIL rst_wait_no_resp got %0d responses want 0", resp_seen); else n_pass++;
    n_total++; if (bus.req_ready !== 1'b1 || bus.mem_req !== 1'b0)
      $display("FAIL rst_wait_idle got ready=%b req=%b want 1/0", bus.req_ready, bus.mem_req); else n_pass++;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh();
    test_sw_split();
    test_lh_wrap();
    test_illegal();
    test_gnt_stall();
    test_reset_mid();
    test_lw();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
